zion_int_ex_arbiter: RTL and testbench
======================================

Name: zion_int_ex_arbiter

Overview:
Shares one combinational integer execution unit (ALU, shifter, adder/sub, SLT, branch/jump, memory address) between REQ_NUM requesters.
- Arbitration is round-robin.
- Each granted op drives the execution unit's operand/control bundle for one cycle.
- The result, branch outcome and memory address are captured into a 2-entry response FIFO with its own valid/ready handshake.
- Sits between the decode lanes (or decode plus address-generation requester) and writeback.

Parameters:
RV64, 0, 1 selects 64-bit datapath (CPU_WIDTH = 64), else 32.
REQ_NUM, 2, number of requesters (2..4).
TAG_W, 4, width of the opaque requester tag carried to the response.
OP_W, 32, width of packed control bundle (add/sub/and/or/xor/slt/shift/branch/jump/mem enables, flags, linkOffset); layout fixed in package.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all buffered responses
reqVld  in  REQ_NUM  per-requester op valid
reqRdy  out  REQ_NUM  per-requester accept (one-hot or zero)
reqOp  in  REQ_NUM*OP_W  packed control bundles
reqPc / reqS1 / reqS2 / reqOffset  in  REQ_NUM*CPU_WIDTH each  operands
reqTag  in  REQ_NUM*TAG_W  tags
exOp  out  OP_W  control to execution unit (zero when no grant)
exPc / exS1 / exS2 / exOffset  out  CPU_WIDTH each  operands to execution unit (zero when no grant)
exIntRslt  in  CPU_WIDTH  execution result
exBjEn  in  2  branch/jump taken code
exBjTgt  in  CPU_WIDTH  branch/jump target
exMemAddr  in  CPU_WIDTH  memory address
rspVld  out  1  FIFO head valid
rspRdy  in  1  consumer accepts head
rspRslt / rspBjTgt / rspMemAddr  out  CPU_WIDTH each  head payload
rspBjEn  out  2  head branch code
rspReqId  out  clog2(REQ_NUM)  originating requester
rspTag  out  TAG_W  originating tag
busyCnt  out  32  saturating count of cycles with a grant

Behaviour:
- Reset (rst=1 at posedge):
  - rrPtr=0, FIFO count=0, rdPtr=wrPtr=0, busyCnt=0.
  - rspVld=0; all rsp payload outputs 0.
  - reqRdy is combinational and must be 0 during the reset cycle.
- Accept condition: fifoHasRoom = (count<2) | (count==2 & rspVld & rspRdy). Same-cycle pop frees a slot.
- Grant (combinational):
  - If fifoHasRoom and ~flush, grant the first requester with reqVld=1, scanning from rrPtr upward modulo REQ_NUM.
  - reqRdy[g]=1 only for the grantee. Grant=none otherwise.
- Exec mux:
  - On grant, ex* = granted requester's op/operands.
  - With no grant, ex* = 0 so the execution unit outputs are zero.
- Capture:
  - On grant, at the next posedge write {exIntRslt, exBjEn, exBjTgt, exMemAddr, g, tag} into FIFO[wrPtr].
  - Then wrPtr++ (mod 2) and rrPtr = (g+1) mod REQ_NUM.
  - Latency from accept to rspVld = 1 cycle.
- rrPtr is unchanged when there is no grant.
- Pop: rspVld & rspRdy advances rdPtr. Push and pop in the same cycle keep count constant.
- Payload stability: rsp* are driven from FIFO[rdPtr] and are zero when count==0. Payload must be stable while rspVld & ~rspRdy.
- Flush:
  - count=0, rdPtr=wrPtr=0 at the next posedge; rspVld=0 the following cycle.
  - No grant in the flush cycle.
  - rrPtr and busyCnt are unchanged.
  - Flush wins over simultaneous push/pop.
- busyCnt increments on every granted cycle and saturates at 0xFFFF_FFFF.
- Requesters may drop reqVld without being granted. No fairness obligation applies to a deasserted requester.
- Throughput: 1 op/cycle sustained when rspRdy=1.

Decomposition:
- Package zion_int_ex_arb_pkg holds:
  - OP_W and op bundle field offsets as a packed struct typedef.
  - The response-entry struct typedef.
  - CPU_WIDTH function of RV64.
- One natural sub-module: zion_rr_arbiter. It is a parameterized round-robin grant from vld and ptr, outputs one-hot grant and index, and is reusable by other shared units.
- The FIFO stays inline (2 entries).

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, reqVld=0 -> rspVld=0, reqRdy=0, busyCnt=0, ex*=0.
2. Single ADD: req0 s1=5, s2=7, addEn; rspRdy=1 -> reqRdy=01 same cycle; next cycle rspVld=1, rspRslt=12, rspReqId=0, tag echoed, busyCnt=1.
3. Round-robin: both requesters hold reqVld for 4 cycles -> grant order 0,1,0,1; responses in the same order with correct tags.
4. Backpressure: rspRdy=0 with continuous req0 -> exactly 2 accepts, then reqRdy=0. Head payload is stable. Raising rspRdy for one cycle gives a same-cycle pop plus new accept, and count stays 2.
5. Flush with count=2 and a pending req -> no grant that cycle, rspVld=0 the next cycle, rrPtr unchanged (next grant order preserved).
6. Branch/memory path: BEQ with s1=s2=3, pc=0x100, offset=0x20 -> rspBjEn taken, rspBjTgt=0x120. Then an LW-style op with s1=0x1000, offset=8 -> rspMemAddr=0x1008. Both checked with RV64=1 as well.

Source files
------------

// File: rtl/zion_int_ex_arb_pkg.sv
// Shared types for the integer execution-unit arbiter: control bundle layout,
// response FIFO entry and datapath width helper.
package zion_int_ex_arb_pkg;

    localparam int unsigned OP_W      = 32;
    localparam int unsigned XLEN_MAX  = 64;
    localparam int unsigned ID_W_MAX  = 2;
    localparam int unsigned TAG_W_MAX = 16;

    // Packed control bundle, MSB first; total width must equal OP_W.
    typedef struct packed {
        logic [15:0] link_offset;
        logic [3:0]  flags;
        logic        mem_en;
        logic        jump_en;
        logic        branch_en;
        logic        sra_en;
        logic        srl_en;
        logic        sll_en;
        logic        slt_en;
        logic        xor_en;
        logic        or_en;
        logic        and_en;
        logic        sub_en;
        logic        add_en;
    } op_t;

    // Sized for the widest configuration; narrower builds leave upper bits unused.
    typedef struct packed {
        logic [XLEN_MAX-1:0]  rslt;
        logic [1:0]           bj_en;
        logic [XLEN_MAX-1:0]  bj_tgt;
        logic [XLEN_MAX-1:0]  mem_addr;
        logic [ID_W_MAX-1:0]  req_id;
        logic [TAG_W_MAX-1:0] tag;
    } rsp_entry_t;

    function automatic int unsigned cpu_width(input int unsigned rv64);
        return (rv64 != 0) ? 64 : 32;
    endfunction

endpackage

// File: rtl/zion_rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping modulo N.
module zion_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vld,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic [IW:0] pos;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int i = 0; i < int'(N); i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!any && vld[pos[IW-1:0]]) begin
                any               = 1'b1;
                gnt[pos[IW-1:0]]  = 1'b1;
                idx               = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/zion_int_ex_arbiter.sv
// Shares one combinational integer execution unit among REQ_NUM requesters and
// buffers its outputs in a 2-entry response FIFO.
module zion_int_ex_arbiter #(
    parameter int unsigned RV64    = 0,
    parameter int unsigned REQ_NUM = 2,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned OP_W    = 32,
    localparam int unsigned CPU_WIDTH = zion_int_ex_arb_pkg::cpu_width(RV64),
    localparam int unsigned ID_W      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [REQ_NUM-1:0]           reqVld,
    output logic [REQ_NUM-1:0]           reqRdy,
    input  logic [REQ_NUM*OP_W-1:0]      reqOp,
    input  logic [REQ_NUM*CPU_WIDTH-1:0] reqPc,
    input  logic [REQ_NUM*CPU_WIDTH-1:0] reqS1,
    input  logic [REQ_NUM*CPU_WIDTH-1:0] reqS2,
    input  logic [REQ_NUM*CPU_WIDTH-1:0] reqOffset,
    input  logic [REQ_NUM*TAG_W-1:0]     reqTag,
    output logic [OP_W-1:0]              exOp,
    output logic [CPU_WIDTH-1:0]         exPc,
    output logic [CPU_WIDTH-1:0]         exS1,
    output logic [CPU_WIDTH-1:0]         exS2,
    output logic [CPU_WIDTH-1:0]         exOffset,
    input  logic [CPU_WIDTH-1:0]         exIntRslt,
    input  logic [1:0]                   exBjEn,
    input  logic [CPU_WIDTH-1:0]         exBjTgt,
    input  logic [CPU_WIDTH-1:0]         exMemAddr,
    output logic                         rspVld,
    input  logic                         rspRdy,
    output logic [CPU_WIDTH-1:0]         rspRslt,
    output logic [CPU_WIDTH-1:0]         rspBjTgt,
    output logic [CPU_WIDTH-1:0]         rspMemAddr,
    output logic [1:0]                   rspBjEn,
    output logic [ID_W-1:0]              rspReqId,
    output logic [TAG_W-1:0]             rspTag,
    output logic [31:0]                  busyCnt
);

    import zion_int_ex_arb_pkg::*;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               wr_ptr_q, rd_ptr_q;
    logic [31:0]        busy_q;
    rsp_entry_t         mem_q [2];
    rsp_entry_t         wr_entry, head;
    logic               pop, has_room;
    logic [REQ_NUM-1:0] arb_vld, gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               unused_head;

    assign rspVld   = (cnt_q != 2'd0);
    assign pop      = rspVld & rspRdy;
    // A same-cycle pop frees the slot the new entry will land in.
    assign has_room = (cnt_q < 2'd2) | ((cnt_q == 2'd2) & pop);
    assign arb_vld  = reqVld & {REQ_NUM{has_room & ~flush & ~rst}};

    zion_rr_arbiter #(
        .N (REQ_NUM)
    ) u_rr_arbiter (
        .vld (arb_vld),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign reqRdy   = gnt;
    assign exOp     = gnt_any ? reqOp[gnt_idx*OP_W +: OP_W] : '0;
    assign exPc     = gnt_any ? reqPc[gnt_idx*CPU_WIDTH +: CPU_WIDTH] : '0;
    assign exS1     = gnt_any ? reqS1[gnt_idx*CPU_WIDTH +: CPU_WIDTH] : '0;
    assign exS2     = gnt_any ? reqS2[gnt_idx*CPU_WIDTH +: CPU_WIDTH] : '0;
    assign exOffset = gnt_any ? reqOffset[gnt_idx*CPU_WIDTH +: CPU_WIDTH] : '0;

    assign rr_ptr_d = (gnt_idx == ID_W'(REQ_NUM - 1)) ? '0 : gnt_idx + ID_W'(1);

    always_comb begin
        wr_entry          = '0;
        wr_entry.rslt     = XLEN_MAX'(exIntRslt);
        wr_entry.bj_en    = exBjEn;
        wr_entry.bj_tgt   = XLEN_MAX'(exBjTgt);
        wr_entry.mem_addr = XLEN_MAX'(exMemAddr);
        wr_entry.req_id   = ID_W_MAX'(gnt_idx);
        wr_entry.tag      = TAG_W_MAX'(reqTag[gnt_idx*TAG_W +: TAG_W]);
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({gnt_any, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            busy_q   <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr_q <= rr_ptr_d;
                if (busy_q != '1) begin
                    busy_q <= busy_q + 32'd1;
                end
            end
            if (flush) begin
                cnt_q    <= '0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (gnt_any) begin
                    mem_q[wr_ptr_q] <= wr_entry;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                cnt_q <= cnt_d;
            end
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign unused_head = ^head;

    assign rspRslt    = rspVld ? head.rslt[CPU_WIDTH-1:0] : '0;
    assign rspBjTgt   = rspVld ? head.bj_tgt[CPU_WIDTH-1:0] : '0;
    assign rspMemAddr = rspVld ? head.mem_addr[CPU_WIDTH-1:0] : '0;
    assign rspBjEn    = rspVld ? head.bj_en : '0;
    assign rspReqId   = rspVld ? head.req_id[ID_W-1:0] : '0;
    assign rspTag     = rspVld ? head.tag[TAG_W-1:0] : '0;
    assign busyCnt    = busy_q;

endmodule

// File: tb/tb_zion_int_ex_arbiter.sv
// Directed bench for zion_int_ex_arbiter: a 32-bit and a 64-bit instance share stimulus.
module tb_zion_int_ex_arbiter;

    import zion_int_ex_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, rsp_rdy;
    logic [1:0]  req_vld;
    logic [31:0] op_a  [2];
    logic [63:0] pc_a  [2];
    logic [63:0] s1_a  [2];
    logic [63:0] s2_a  [2];
    logic [63:0] off_a [2];
    logic [3:0]  tag_a [2];

    int checks = 0;
    int passed = 0;

    logic [63:0]  req_op;
    logic [7:0]   req_tag;
    logic [63:0]  req_pc_n, req_s1_n, req_s2_n, req_off_n;
    logic [127:0] req_pc_w, req_s1_w, req_s2_w, req_off_w;

    assign req_op    = {op_a[1], op_a[0]};
    assign req_tag   = {tag_a[1], tag_a[0]};
    assign req_pc_n  = {pc_a[1][31:0], pc_a[0][31:0]};
    assign req_s1_n  = {s1_a[1][31:0], s1_a[0][31:0]};
    assign req_s2_n  = {s2_a[1][31:0], s2_a[0][31:0]};
    assign req_off_n = {off_a[1][31:0], off_a[0][31:0]};
    assign req_pc_w  = {pc_a[1], pc_a[0]};
    assign req_s1_w  = {s1_a[1], s1_a[0]};
    assign req_s2_w  = {s2_a[1], s2_a[0]};
    assign req_off_w = {off_a[1], off_a[0]};

    // Narrow instance signals
    logic [1:0]  rdy_n, rsp_bj_n, bj_en_n;
    logic [31:0] ex_op_n, ex_pc_n, ex_s1_n, ex_s2_n, ex_off_n;
    logic [31:0] rslt_n, bj_tgt_n, mem_n;
    logic        rsp_vld_n;
    logic [31:0] rsp_rslt_n, rsp_tgt_n, rsp_mem_n, busy_n;
    logic [0:0]  rsp_id_n;
    logic [3:0]  rsp_tag_n;

    // Wide instance signals
    logic [1:0]  rdy_w, rsp_bj_w, bj_en_w;
    logic [31:0] ex_op_w, busy_w;
    logic [63:0] ex_pc_w, ex_s1_w, ex_s2_w, ex_off_w;
    logic [63:0] rslt_w, bj_tgt_w, mem_w;
    logic        rsp_vld_w;
    logic [63:0] rsp_rslt_w, rsp_tgt_w, rsp_mem_w;
    logic [0:0]  rsp_id_w;
    logic [3:0]  rsp_tag_w;

    // Stand-in execution units: add/sub, BEQ-style branch, load/store address.
    op_t m_n, m_w;
    assign m_n      = op_t'(ex_op_n);
    assign rslt_n   = m_n.add_en ? ex_s1_n + ex_s2_n : (m_n.sub_en ? ex_s1_n - ex_s2_n : '0);
    assign bj_en_n  = (m_n.branch_en && ex_s1_n == ex_s2_n) ? 2'b01 : 2'b00;
    assign bj_tgt_n = m_n.branch_en ? ex_pc_n + ex_off_n : '0;
    assign mem_n    = m_n.mem_en ? ex_s1_n + ex_off_n : '0;
    assign m_w      = op_t'(ex_op_w);
    assign rslt_w   = m_w.add_en ? ex_s1_w + ex_s2_w : (m_w.sub_en ? ex_s1_w - ex_s2_w : '0);
    assign bj_en_w  = (m_w.branch_en && ex_s1_w == ex_s2_w) ? 2'b01 : 2'b00;
    assign bj_tgt_w = m_w.branch_en ? ex_pc_w + ex_off_w : '0;
    assign mem_w    = m_w.mem_en ? ex_s1_w + ex_off_w : '0;

    zion_int_ex_arbiter #(.RV64(0), .REQ_NUM(2), .TAG_W(4), .OP_W(32)) dut_n (
        .clk(clk), .rst(rst), .flush(flush), .reqVld(req_vld), .reqRdy(rdy_n),
        .reqOp(req_op), .reqPc(req_pc_n), .reqS1(req_s1_n), .reqS2(req_s2_n),
        .reqOffset(req_off_n), .reqTag(req_tag), .exOp(ex_op_n), .exPc(ex_pc_n),
        .exS1(ex_s1_n), .exS2(ex_s2_n), .exOffset(ex_off_n), .exIntRslt(rslt_n),
        .exBjEn(bj_en_n), .exBjTgt(bj_tgt_n), .exMemAddr(mem_n), .rspVld(rsp_vld_n),
        .rspRdy(rsp_rdy), .rspRslt(rsp_rslt_n), .rspBjTgt(rsp_tgt_n), .rspMemAddr(rsp_mem_n),
        .rspBjEn(rsp_bj_n), .rspReqId(rsp_id_n), .rspTag(rsp_tag_n), .busyCnt(busy_n)
    );

    zion_int_ex_arbiter #(.RV64(1), .REQ_NUM(2), .TAG_W(4), .OP_W(32)) dut_w (
        .clk(clk), .rst(rst), .flush(flush), .reqVld(req_vld), .reqRdy(rdy_w),
        .reqOp(req_op), .reqPc(req_pc_w), .reqS1(req_s1_w), .reqS2(req_s2_w),
        .reqOffset(req_off_w), .reqTag(req_tag), .exOp(ex_op_w), .exPc(ex_pc_w),
        .exS1(ex_s1_w), .exS2(ex_s2_w), .exOffset(ex_off_w), .exIntRslt(rslt_w),
        .exBjEn(bj_en_w), .exBjTgt(bj_tgt_w), .exMemAddr(mem_w), .rspVld(rsp_vld_w),
        .rspRdy(rsp_rdy), .rspRslt(rsp_rslt_w), .rspBjTgt(rsp_tgt_w), .rspMemAddr(rsp_mem_w),
        .rspBjEn(rsp_bj_w), .rspReqId(rsp_id_w), .rspTag(rsp_tag_w), .busyCnt(busy_w)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 2; i++) begin
            op_a[i] = '0; pc_a[i] = '0; s1_a[i] = '0; s2_a[i] = '0; off_a[i] = '0;
            tag_a[i] = '0;
        end
    endtask

    function automatic logic [31:0] mk_op(input bit add, input bit sub, input bit br,
                                          input bit mem);
        op_t o;
        o           = '0;
        o.add_en    = add;
        o.sub_en    = sub;
        o.branch_en = br;
        o.mem_en    = mem;
        return 32'(o);
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_vld = 2'b01; op_a[0] = mk_op(1, 0, 0, 0); s1_a[0] = 64'd9;
        @(negedge clk);
        checks++; if (rdy_n !== 2'b00) $display("FAIL reset_rdy_n: got %b want 00", rdy_n); else passed++;
        checks++; if (rdy_w !== 2'b00) $display("FAIL reset_rdy_w: got %b want 00", rdy_w); else passed++;
        checks++; if (ex_s1_n !== 32'd0) $display("FAIL reset_ex_s1: got %0h want 0", ex_s1_n); else passed++;
        tick();
        tick();
        rst = 1'b0; req_vld = 2'b00;
        @(negedge clk);
        checks++; if (rsp_vld_n !== 1'b0) $display("FAIL idle_rsp_vld: got %b want 0", rsp_vld_n); else passed++;
        checks++; if (rsp_vld_w !== 1'b0) $display("FAIL idle_rsp_vld_w: got %b want 0", rsp_vld_w); else passed++;
        checks++; if (busy_n !== 32'd0) $display("FAIL idle_busy: got %0d want 0", busy_n); else passed++;
        checks++; if (ex_op_n !== 32'd0) $display("FAIL idle_ex_op: got %0h want 0", ex_op_n); else passed++;
        checks++; if (rsp_rslt_n !== 32'd0) $display("FAIL idle_rsp_rslt: got %0h want 0", rsp_rslt_n); else passed++;
        tick();
    endtask

    task automatic test_single_add();
        op_a[0] = mk_op(1, 0, 0, 0); s1_a[0] = 64'd5; s2_a[0] = 64'd7; tag_a[0] = 4'hA;
        req_vld = 2'b01; rsp_rdy = 1'b1;
        @(negedge clk);
        checks++; if (rdy_n !== 2'b01) $display("FAIL add_rdy: got %b want 01", rdy_n); else passed++;
        checks++; if (ex_s2_n !== 32'd7) $display("FAIL add_ex_s2: got %0d want 7", ex_s2_n); else passed++;
        tick();
        req_vld = 2'b00;
        @(negedge clk);
        checks++; if (rsp_vld_n !== 1'b1) $display("FAIL add_rsp_vld: got %b want 1", rsp_vld_n); else passed++;
        checks++; if (rsp_rslt_n !== 32'd12) $display("FAIL add_rslt: got %0d want 12", rsp_rslt_n); else passed++;
        checks++; if (rsp_id_n !== 1'b0) $display("FAIL add_id: got %0d want 0", rsp_id_n); else passed++;
        checks++; if (rsp_tag_n !== 4'hA) $display("FAIL add_tag: got %0h want a", rsp_tag_n); else passed++;
        checks++; if (busy_n !== 32'd1) $display("FAIL add_busy: got %0d want 1", busy_n); else passed++;
        tick();
        @(negedge clk);
        checks++; if (rsp_vld_n !== 1'b0) $display("FAIL add_popped: got %b want 0", rsp_vld_n); else passed++;
        checks++; if (rsp_tag_n !== 4'h0) $display("FAIL add_empty_tag: got %0h want 0", rsp_tag_n); else passed++;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [0:0]  exp_id;
        logic [3:0]  exp_tag;
        logic [31:0] exp_rslt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        op_a[0] = mk_op(1, 0, 0, 0); s1_a[0] = 64'd10; s2_a[0] = 64'd1; tag_a[0] = 4'd1;
        op_a[1] = mk_op(0, 1, 0, 0); s1_a[1] = 64'd20; s2_a[1] = 64'd3; tag_a[1] = 4'd2;
        req_vld = 2'b11; rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
            checks++; if (rdy_n !== exp_rdy) $display("FAIL rr_rdy[%0d]: got %b want %b", i, rdy_n, exp_rdy); else passed++;
            if (i > 0) begin
                exp_id   = (i % 2 == 1) ? 1'b0 : 1'b1;
                exp_tag  = (i % 2 == 1) ? 4'd1 : 4'd2;
                exp_rslt = (i % 2 == 1) ? 32'd11 : 32'd17;
                checks++; if (rsp_id_n !== exp_id) $display("FAIL rr_id[%0d]: got %0d want %0d", i, rsp_id_n, exp_id); else passed++;
                checks++; if (rsp_tag_n !== exp_tag) $display("FAIL rr_tag[%0d]: got %0d want %0d", i, rsp_tag_n, exp_tag); else passed++;
                checks++; if (rsp_rslt_n !== exp_rslt) $display("FAIL rr_rslt[%0d]: got %0d want %0d", i, rsp_rslt_n, exp_rslt); else passed++;
            end
            tick();
        end
        req_vld = 2'b00;
        @(negedge clk);
        checks++; if (rsp_id_n !== 1'b1) $display("FAIL rr_last_id: got %0d want 1", rsp_id_n); else passed++;
        checks++; if (rsp_rslt_n !== 32'd17) $display("FAIL rr_last_rslt: got %0d want 17", rsp_rslt_n); else passed++;
        checks++; if (busy_n !== 32'd4) $display("FAIL rr_busy: got %0d want 4", busy_n); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [1:0]  rdy_tab  [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        logic        pop_tab  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] rslt_tab [6] = '{32'd0, 32'd107, 32'd107, 32'd107, 32'd107, 32'd108};
        op_a[0] = mk_op(1, 0, 0, 0); s2_a[0] = 64'd7; tag_a[0] = 4'd3;
        req_vld = 2'b01;
        for (int c = 0; c < 6; c++) begin
            s1_a[0] = 64'(100 + c);
            rsp_rdy = pop_tab[c];
            @(negedge clk);
            checks++; if (rdy_n !== rdy_tab[c]) $display("FAIL bp_rdy[%0d]: got %b want %b", c, rdy_n, rdy_tab[c]); else passed++;
            if (c > 0) begin
                checks++; if (rsp_rslt_n !== rslt_tab[c]) $display("FAIL bp_head[%0d]: got %0d want %0d", c, rsp_rslt_n, rslt_tab[c]); else passed++;
                checks++; if (rsp_vld_n !== 1'b1) $display("FAIL bp_vld[%0d]: got %b want 1", c, rsp_vld_n); else passed++;
            end
            if (c < 5) tick();
        end
        checks++; if (busy_n !== 32'd7) $display("FAIL bp_busy: got %0d want 7", busy_n); else passed++;
        tick();
    endtask

    task automatic test_flush();
        req_vld = 2'b11; rsp_rdy = 1'b1; flush = 1'b1;
        @(negedge clk);
        checks++; if (rdy_n !== 2'b00) $display("FAIL flush_rdy: got %b want 00", rdy_n); else passed++;
        checks++; if (ex_op_n !== 32'd0) $display("FAIL flush_ex_op: got %0h want 0", ex_op_n); else passed++;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (rsp_vld_n !== 1'b0) $display("FAIL flush_rsp_vld: got %b want 0", rsp_vld_n); else passed++;
        checks++; if (rsp_rslt_n !== 32'd0) $display("FAIL flush_rsp_rslt: got %0d want 0", rsp_rslt_n); else passed++;
        checks++; if (rdy_n !== 2'b10) $display("FAIL flush_rr_kept: got %b want 10", rdy_n); else passed++;
        checks++; if (busy_n !== 32'd7) $display("FAIL flush_busy: got %0d want 7", busy_n); else passed++;
        tick();
        req_vld = 2'b00;
        @(negedge clk);
        checks++; if (rsp_id_n !== 1'b1) $display("FAIL flush_next_id: got %0d want 1", rsp_id_n); else passed++;
        checks++; if (rsp_rslt_n !== 32'd17) $display("FAIL flush_next_rslt: got %0d want 17", rsp_rslt_n); else passed++;
        checks++; if (busy_n !== 32'd8) $display("FAIL flush_next_busy: got %0d want 8", busy_n); else passed++;
        tick();
    endtask

    task automatic test_branch_mem();
        clear_reqs();
        op_a[0] = mk_op(0, 0, 1, 0); s1_a[0] = 64'd3; s2_a[0] = 64'd3;
        pc_a[0] = 64'h100; off_a[0] = 64'h20; tag_a[0] = 4'd5;
        req_vld = 2'b01; rsp_rdy = 1'b1;
        @(negedge clk);
        checks++; if (rdy_w !== 2'b01) $display("FAIL br_rdy_w: got %b want 01", rdy_w); else passed++;
        tick();
        op_a[0] = mk_op(0, 0, 0, 1); s1_a[0] = 64'h1_0000_1000; s2_a[0] = '0;
        pc_a[0] = '0; off_a[0] = 64'h8; tag_a[0] = 4'd6;
        @(negedge clk);
        checks++; if (rsp_bj_n !== 2'b01) $display("FAIL br_bj_n: got %b want 01", rsp_bj_n); else passed++;
        checks++; if (rsp_tgt_n !== 32'h120) $display("FAIL br_tgt_n: got %0h want 120", rsp_tgt_n); else passed++;
        checks++; if (rsp_bj_w !== 2'b01) $display("FAIL br_bj_w: got %b want 01", rsp_bj_w); else passed++;
        checks++; if (rsp_tgt_w !== 64'h120) $display("FAIL br_tgt_w: got %0h want 120", rsp_tgt_w); else passed++;
        checks++; if (rsp_tag_n !== 4'd5) $display("FAIL br_tag: got %0d want 5", rsp_tag_n); else passed++;
        tick();
        req_vld = 2'b00;
        @(negedge clk);
        checks++; if (rsp_mem_n !== 32'h1008) $display("FAIL mem_addr_n: got %0h want 1008", rsp_mem_n); else passed++;
        checks++; if (rsp_mem_w !== 64'h1_0000_1008) $display("FAIL mem_addr_w: got %0h want 100001008", rsp_mem_w); else passed++;
        checks++; if (rsp_bj_w !== 2'b00) $display("FAIL mem_bj_w: got %b want 00", rsp_bj_w); else passed++;
        checks++; if (rsp_tag_w !== 4'd6) $display("FAIL mem_tag_w: got %0d want 6", rsp_tag_w); else passed++;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rsp_rdy = 1'b1; req_vld = 2'b00;
        clear_reqs();
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_branch_mem();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
